// File: rtl/doodle_painter.sv
// rtl/doodle_painter.sv - two-stage pixel painter: player box and platform boxes over a background, double-buffered at frame edges
// Optional PAINTER_DEBUG_GRID_EN: 64-px white grid on background pixels.
module doodle_painter #(
  parameter int H_VIS_START    = 160,
  parameter int V_VIS_START    = 28,
  parameter int SPRITE_W       = 32,
  parameter int SPRITE_H       = 32,
  parameter int PLATFORM_COUNT = 4,
  parameter int PLATFORM_W     = 64,
  parameter int PLATFORM_H     = 8,
  localparam int IDX_W = (PLATFORM_COUNT > 1) ? $clog2(PLATFORM_COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      beam_x,
  input  logic [9:0]       beam_y,
  input  logic             valid,
  input  logic             switch_line,
  input  logic             switch_frame,
  input  logic             player_we,
  input  logic [9:0]       player_x,
  input  logic [9:0]       player_y,
  input  logic             plat_we,
  input  logic [IDX_W-1:0] plat_idx,
  input  logic             plat_en,
  input  logic [9:0]       plat_x,
  input  logic [9:0]       plat_y,
  output logic             red,
  output logic             green,
  output logic             blue,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  logic [9:0] pend_px, pend_py, act_px, act_py;
  logic [PLATFORM_COUNT-1:0] pend_en, act_en;
  logic [9:0] pend_x [PLATFORM_COUNT];
  logic [9:0] pend_y [PLATFORM_COUNT];
  logic [9:0] act_x  [PLATFORM_COUNT];
  logic [9:0] act_y  [PLATFORM_COUNT];

  logic        sf_prev;
  logic [10:0] s1_px;
  logic [9:0]  s1_py;
  logic        s1_valid, s1_hs, s1_vs;
  logic        frame_edge;
  logic        player_hit, plat_hit;
  logic [2:0]  rgb_nxt;

  assign frame_edge = switch_frame & ~sf_prev;

  // Box bounds are widened to 11 bits so boxes near the right/bottom edge clip instead of wrapping to 0.
  always_comb begin
    player_hit = (s1_px >= {1'b0, act_px}) && (s1_px < ({1'b0, act_px} + 11'(SPRITE_W)))
              && ({1'b0, s1_py} >= {1'b0, act_py}) && ({1'b0, s1_py} < ({1'b0, act_py} + 11'(SPRITE_H)));
    plat_hit = 1'b0;
    for (int i = 0; i < PLATFORM_COUNT; i++) begin
      if (act_en[i]
          && (s1_px >= {1'b0, act_x[i]}) && (s1_px < ({1'b0, act_x[i]} + 11'(PLATFORM_W)))
          && ({1'b0, s1_py} >= {1'b0, act_y[i]}) && ({1'b0, s1_py} < ({1'b0, act_y[i]} + 11'(PLATFORM_H))))
        plat_hit = 1'b1;
    end
    if (!s1_valid)      rgb_nxt = 3'b000;
    else if (player_hit) rgb_nxt = 3'b100;
    else if (plat_hit)   rgb_nxt = 3'b010;
`ifdef PAINTER_DEBUG_GRID_EN
    else if ((s1_px[5:0] == 6'd0) || (s1_py[5:0] == 6'd0)) rgb_nxt = 3'b111;
`endif
    else                 rgb_nxt = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sf_prev     <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= 16'd0;
      pend_px     <= '0;
      pend_py     <= '0;
      act_px      <= '0;
      act_py      <= '0;
      pend_en     <= '0;
      act_en      <= '0;
      for (int i = 0; i < PLATFORM_COUNT; i++) begin
        pend_x[i] <= '0;
        pend_y[i] <= '0;
        act_x[i]  <= '0;
        act_y[i]  <= '0;
      end
      s1_px    <= '0;
      s1_py    <= '0;
      s1_valid <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      {red, green, blue} <= 3'b000;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
    end else begin
      sf_prev     <= switch_frame;
      frame_start <= frame_edge;
      // Commit reads the old pending set; a same-cycle write only updates pending.
      if (frame_edge) begin
        frame_count <= frame_count + 16'd1;
        act_px      <= pend_px;
        act_py      <= pend_py;
        act_en      <= pend_en;
        for (int i = 0; i < PLATFORM_COUNT; i++) begin
          act_x[i] <= pend_x[i];
          act_y[i] <= pend_y[i];
        end
      end
      if (player_we) begin
        pend_px <= player_x;
        pend_py <= player_y;
      end
      if (plat_we) begin
        pend_en[plat_idx] <= plat_en;
        pend_x[plat_idx]  <= plat_x;
        pend_y[plat_idx]  <= plat_y;
      end
      s1_px    <= beam_x - 11'(H_VIS_START);
      s1_py    <= beam_y - 10'(V_VIS_START);
      s1_valid <= valid;
      s1_hs    <= switch_line;
      s1_vs    <= switch_frame;
      {red, green, blue} <= rgb_nxt;
      hsync    <= s1_hs;
      vsync    <= s1_vs;
    end
  end

endmodule

// File: tb/tb_doodle_painter.sv
// tb/tb_doodle_painter.sv - scoreboard bench for doodle_painter
module tb_doodle_painter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] beam_x = '0;
  logic [9:0]  beam_y = '0;
  logic        valid = 1'b0, switch_line = 1'b0, switch_frame = 1'b0;
  logic        player_we = 1'b0;
  logic [9:0]  player_x = '0, player_y = '0;
  logic        plat_we = 1'b0;
  logic [1:0]  plat_idx = '0;
  logic        plat_en = 1'b0;
  logic [9:0]  plat_x = '0, plat_y = '0;
  logic        red, green, blue, hsync, vsync, frame_start;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  doodle_painter dut (
    .clk(clk), .rst(rst), .beam_x(beam_x), .beam_y(beam_y), .valid(valid),
    .switch_line(switch_line), .switch_frame(switch_frame),
    .player_we(player_we), .player_x(player_x), .player_y(player_y),
    .plat_we(plat_we), .plat_idx(plat_idx), .plat_en(plat_en), .plat_x(plat_x), .plat_y(plat_y),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  logic [4:0] exp_q[$];
  string      tag_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cur_vs = 0;

  int m_pend_px, m_pend_py, m_act_px, m_act_py, m_count;
  int m_pend_x[4], m_pend_y[4], m_act_x[4], m_act_y[4];
  bit m_pend_en[4], m_act_en[4];
  bit m_sf_prev;

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit inbox(int px, int py, int x, int y, int w, int h);
    return (px >= x) && (px < x + w) && (py >= y) && (py < y + h);
  endfunction

  // Expected {r,g,b,hsync,vsync} two cycles after these beam inputs.
  function automatic logic [4:0] model_pix(int bx, int by, bit v, bit hs, bit vs);
    int px, py;
    bit ph, qh;
    logic [2:0] c;
    px = (bx - 160) & 'h7FF;
    py = (by - 28) & 'h3FF;
    ph = inbox(px, py, m_act_px, m_act_py, 32, 32);
    qh = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_act_en[i] && inbox(px, py, m_act_x[i], m_act_y[i], 64, 8)) qh = 1'b1;
    if (!v) c = 3'b000;
    else if (ph) c = 3'b100;
    else if (qh) c = 3'b010;
`ifdef PAINTER_DEBUG_GRID_EN
    else if ((px % 64) == 0 || (py % 64) == 0) c = 3'b111;
`endif
    else c = 3'b001;
    return {c, hs, vs};
  endfunction

  task automatic model_reset();
    m_pend_px = 0; m_pend_py = 0; m_act_px = 0; m_act_py = 0; m_count = 0;
    m_sf_prev = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_pend_x[i] = 0; m_pend_y[i] = 0; m_act_x[i] = 0; m_act_y[i] = 0;
      m_pend_en[i] = 1'b0; m_act_en[i] = 1'b0;
    end
  endtask

  // Called at a negedge: compare the pixel pushed two steps ago, drive new inputs, push its expectation.
  task automatic step(int bx, int by, bit v, bit hs, bit vs, string tag);
    bit fedge;
    if (exp_q.size() == 2)
      check({tag_q.pop_front(), " rgb_hv"}, {11'd0, red, green, blue, hsync, vsync}, {11'd0, exp_q.pop_front()});
    beam_x = 11'(bx); beam_y = 10'(by); valid = v; switch_line = hs; switch_frame = vs;
    fedge = vs && !m_sf_prev;
    m_sf_prev = vs;
    if (fedge) begin
      m_count = (m_count + 1) & 'hFFFF;
      m_act_px = m_pend_px; m_act_py = m_pend_py;
      for (int i = 0; i < 4; i++) begin
        m_act_x[i] = m_pend_x[i]; m_act_y[i] = m_pend_y[i]; m_act_en[i] = m_pend_en[i];
      end
    end
    if (player_we) begin
      m_pend_px = player_x; m_pend_py = player_y;
    end
    if (plat_we) begin
      m_pend_x[plat_idx] = plat_x; m_pend_y[plat_idx] = plat_y; m_pend_en[plat_idx] = plat_en;
    end
    exp_q.push_back(model_pix(bx, by, v, hs, vs));
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, " frame_start"}, {15'd0, frame_start}, {15'd0, fedge});
    check({tag, " frame_count"}, frame_count, 16'(m_count));
    player_we = 1'b0;
    plat_we = 1'b0;
  endtask

  task automatic do_reset(bit vs);
    rst = 1'b1;
    switch_frame = vs; valid = 1'b1; switch_line = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset outputs", {11'd0, red, green, blue, hsync, vsync}, 16'd0);
    check("reset frame_start", {15'd0, frame_start}, 16'd0);
    check("reset frame_count", frame_count, 16'd0);
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    exp_q.push_back(5'b0);
    tag_q.push_back("post-reset");
    model_reset();
    cur_vs = vs;
  endtask

  task automatic pix(int px, int py, string tag);
    step(px + 160, py + 28, 1'b1, 1'b0, cur_vs[0], tag);
  endtask

  task automatic blank(string tag);
    step(0, 0, 1'b0, 1'b0, cur_vs[0], tag);
  endtask

  task automatic frame();
    step(0, 0, 1'b0, 1'b0, 1'b1, "frame rise");
    step(0, 0, 1'b0, 1'b0, 1'b0, "frame fall");
    cur_vs = 0;
  endtask

  task automatic wr_player(int x, int y);
    player_we = 1'b1; player_x = 10'(x); player_y = 10'(y);
    pix(x, y, "player write");
  endtask

  task automatic wr_plat(int idx, bit en, int x, int y);
    plat_we = 1'b1; plat_idx = 2'(idx); plat_en = en; plat_x = 10'(x); plat_y = 10'(y);
    blank("plat write");
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1, "held vs after reset");
    step(0, 0, 1'b0, 1'b1, 1'b1, "hs rise");
    cur_vs = 0;
    blank("blank");
    pix(0, 0, "bg origin");
    pix(500, 300, "bg mid");
    step(159, 28, 1'b0, 1'b1, 1'b0, "hblank");
    pix(1023, 767, "bg corner");
    frame();
    blank("after first frame");

    wr_player(100, 50);
    pix(100, 50, "player pending");
    frame();
    pix(99, 50, "player left-1");
    pix(100, 50, "player left");
    pix(131, 81, "player br");
    pix(132, 50, "player right+1");
    pix(100, 82, "player bottom+1");

    wr_plat(2, 1'b1, 980, 700);
    frame();
    pix(979, 700, "plat2 left-1");
    pix(980, 700, "plat2 left");
    pix(1023, 707, "plat2 edge");
    pix(0, 700, "plat2 no wrap 0");
    pix(19, 700, "plat2 no wrap 19");
    pix(1000, 708, "plat2 below");

    wr_player(10, 10);
    wr_plat(0, 1'b1, 0, 20);
    frame();
    pix(15, 25, "overlap");
    pix(5, 25, "plat0 only");
    pix(45, 25, "plat0 past player");
    pix(15, 15, "player above plat");

    plat_we = 1'b1; plat_idx = 2'd1; plat_en = 1'b1; plat_x = 10'd300; plat_y = 10'd300;
    step(0, 0, 1'b0, 1'b0, 1'b1, "write at commit");
    cur_vs = 1;
    pix(300, 300, "plat1 not yet");
    frame();
    pix(300, 300, "plat1 next frame");

    wr_player(200, 100);
    wr_player(400, 100);
    frame();
    pix(400, 100, "last write wins");
    pix(200, 100, "first write lost");

`ifdef PAINTER_DEBUG_GRID_EN
    pix(64, 5, "grid white");
    pix(65, 5, "grid off");
    pix(15, 25, "grid under player");
`endif

    step(0, 0, 1'b0, 1'b0, 1'b1, "vs high before rst");
    cur_vs = 1;
    pix(15, 25, "mid-line");
    do_reset(1'b1);
    pix(15, 25, "post rst vs high");
    pix(400, 100, "post rst cleared");
    pix(300, 300, "post rst plat");
    frame();
    pix(400, 100, "post rst frame");
    blank("drain 1");
    blank("drain 2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
